// File: rtl/dataflow_merge_arbiter.sv
// Two-input round-robin merge for valid/ready streams.
// Grants one source for a whole burst and registers the output beat.
module dataflow_merge_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              i_valid,
    output logic [1:0]              i_ready,
    input  logic [2*DATA_WIDTH-1:0] i_data,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_sel,
    output logic                    o_last
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            grant;
    logic            grant_nxt;
    logic            last_served;
    logic            last_served_nxt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            load_en;
    logic            xfer;
    logic            burst_end;
    logic [DATA_WIDTH-1:0] sel_data;

    assign load_en = !o_valid || o_ready;

    // Ready depends only on state and o_ready, never on i_valid.
    always_comb begin
        i_ready = 2'b00;
        if (state == LOCK && load_en) begin
            i_ready[grant] = 1'b1;
        end
    end

    assign xfer      = |(i_valid & i_ready);
    assign burst_end = xfer && (count == LAST_CNT);
    assign sel_data  = grant ? i_data[DATA_WIDTH +: DATA_WIDTH]
                             : i_data[0 +: DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 1'b0;
            count       <= '0;
            last_served <= 1'b1;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            count       <= count_nxt;
            last_served <= last_served_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        count_nxt       = count;
        last_served_nxt = last_served;
        unique case (state)
            IDLE: begin
                if (|i_valid) begin
                    state_nxt = LOCK;
                    count_nxt = '0;
                    grant_nxt = (&i_valid) ? ~last_served : i_valid[1];
                end
            end
            LOCK: begin
                if (burst_end) begin
                    state_nxt       = IDLE;
                    count_nxt       = '0;
                    last_served_nxt = grant;
                end else if (xfer) begin
                    count_nxt = count + CW'(1);
                end
            end
        endcase
    end

    // Output register: load on transfer, drain on o_ready, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sel   <= 1'b0;
            o_last  <= 1'b0;
        end else if (xfer) begin
            o_valid <= 1'b1;
            o_data  <= sel_data;
            o_sel   <= grant;
            o_last  <= (count == LAST_CNT);
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dataflow_merge_arbiter.sv
// Bench for dataflow_merge_arbiter: BURST_LEN=2 and BURST_LEN=1 instances
// share handshakes and are compared each cycle against a burst-level model.
module tb_dataflow_merge_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  vld;
    logic        ordy;
    logic [31:0] base [2];
    logic [31:0] seq  [2][2];
    logic [63:0] idat [2];
    logic [1:0]  rdy  [2];
    logic        ov   [2];
    logic [31:0] od   [2];
    logic        os   [2];
    logic        ol   [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 0;

    typedef struct {
        bit          busy;
        bit          owner;
        int          done;
        bit          prev;
        bit          full;
        logic [31:0] data;
        bit          sel;
        bit          last;
    } mdl_t;

    typedef struct {
        int          cyc;
        bit          sel;
        bit          last;
        logic [31:0] data;
    } beat_t;

    mdl_t  m [2];
    beat_t lg0[$];
    beat_t lg1[$];

    always #5 clk = ~clk;

    dataflow_merge_arbiter #(.DATA_WIDTH(32), .BURST_LEN(2)) dut0 (
        .clk(clk), .reset(reset), .i_valid(vld), .i_ready(rdy[0]),
        .i_data(idat[0]), .o_valid(ov[0]), .o_ready(ordy),
        .o_data(od[0]), .o_sel(os[0]), .o_last(ol[0])
    );

    dataflow_merge_arbiter #(.DATA_WIDTH(32), .BURST_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .i_valid(vld), .i_ready(rdy[1]),
        .i_data(idat[1]), .o_valid(ov[1]), .o_ready(ordy),
        .o_data(od[1]), .o_sel(os[1]), .o_last(ol[1])
    );

    // Each source presents base + number of beats it has had accepted.
    assign idat[0] = {base[1] + seq[0][1], base[0] + seq[0][0]};
    assign idat[1] = {base[1] + seq[1][1], base[1 - 1] + seq[1][0]};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 2; n++) begin
                if (reset)
                    seq[k][n] <= 32'd0;
                else if (vld[n] && rdy[k][n])
                    seq[k][n] <= seq[k][n] + 32'd1;
            end
        end
    end

    function automatic mdl_t step(mdl_t s, int bl, logic rst,
                                  logic [1:0] v, logic ordy_i,
                                  logic [63:0] d);
        mdl_t n;
        bit   take;
        n = s;
        if (rst) begin
            n.busy = 0; n.owner = 0; n.done = 0; n.prev = 1;
            n.full = 0; n.data = '0; n.sel = 0; n.last = 0;
            return n;
        end
        take = s.busy && v[s.owner] && (!s.full || ordy_i);
        if (take) begin
            n.data = s.owner ? d[63:32] : d[31:0];
            n.sel  = s.owner;
            n.done = s.done + 1;
            n.last = (n.done == bl);
            n.full = 1;
            if (n.done == bl) begin
                n.busy = 0;
                n.prev = s.owner;
            end
        end else if (ordy_i) begin
            n.full = 0;
        end
        if (!s.busy && v != 2'b00) begin
            n.busy  = 1;
            n.done  = 0;
            n.owner = (v == 2'b11) ? !s.prev : v[1];
        end
        return n;
    endfunction

    function automatic logic [1:0] exp_rdy(mdl_t s, logic ordy_i);
        if (s.busy && (!s.full || ordy_i))
            return s.owner ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        m[0] <= step(m[0], 2, reset, vld, ordy, idat[0]);
        m[1] <= step(m[1], 1, reset, vld, ordy, idat[1]);
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("dut%0d o_valid", k), 32'(ov[k]), 32'(m[k].full));
                check($sformatf("dut%0d o_data", k), od[k], m[k].data);
                check($sformatf("dut%0d o_sel", k), 32'(os[k]), 32'(m[k].sel));
                check($sformatf("dut%0d o_last", k), 32'(ol[k]), 32'(m[k].last));
                check($sformatf("dut%0d i_ready", k), 32'(rdy[k]),
                      32'(exp_rdy(m[k], ordy)));
            end
        end
        if (!reset && ordy) begin
            if (ov[0]) lg0.push_back('{cyc, os[0], ol[0], od[0]});
            if (ov[1]) lg1.push_back('{cyc, os[1], ol[1], od[1]});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        tick(2);
        reset = 1'b0;
        lg0.delete();
        lg1.delete();
    endtask

    task automatic wait_seq(input int k, input int n, input logic [31:0] tgt,
                            input string nm);
        int t = 0;
        while (seq[k][n] < tgt && t < 20) begin
            tick(1);
            t++;
        end
        check(nm, 32'(seq[k][n] >= tgt), 32'd1);
    endtask

    int sA0[4] = '{0, 0, 1, 1};
    int lA0[4] = '{0, 1, 0, 1};
    int dA0[4] = '{32'h100, 32'h101, 32'h200, 32'h201};
    int cA0[4] = '{2, 3, 5, 6};
    int sA1[4] = '{0, 1, 0, 1};
    int dA1[4] = '{32'h100, 32'h200, 32'h101, 32'h201};
    int c0;
    int rel;
    int t;
    bit r0seen;

    initial begin
        reset   = 1'b1;
        vld     = 2'b00;
        ordy    = 1'b1;
        base[0] = 32'h100;
        base[1] = 32'h200;
        do_reset();
        chk_en = 1;
        @(negedge clk);
        check("reset o_valid", 32'(ov[0]), 32'd0);
        check("reset i_ready", 32'(rdy[0]), 32'd0);

        // Both sources requesting continuously.
        tick(1);
        vld = 2'b11;
        c0  = cyc;
        tick(12);
        check("A0 beats", 32'(lg0.size() >= 4), 32'd1);
        check("A1 beats", 32'(lg1.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < lg0.size(); i++) begin
            check($sformatf("A0 sel%0d", i), 32'(lg0[i].sel), 32'(sA0[i]));
            check($sformatf("A0 last%0d", i), 32'(lg0[i].last), 32'(lA0[i]));
            check($sformatf("A0 data%0d", i), lg0[i].data, 32'(dA0[i]));
            check($sformatf("A0 cyc%0d", i), 32'(lg0[i].cyc - c0), 32'(cA0[i]));
        end
        for (int i = 0; i < 4 && i < lg1.size(); i++) begin
            check($sformatf("A1 sel%0d", i), 32'(lg1[i].sel), 32'(sA1[i]));
            check($sformatf("A1 last%0d", i), 32'(lg1[i].last), 32'd1);
            check($sformatf("A1 data%0d", i), lg1[i].data, 32'(dA1[i]));
            check($sformatf("A1 cyc%0d", i), 32'(lg1[i].cyc - c0), 32'(2 + 2 * i));
        end

        // Only source 1 requests.
        vld     = 2'b00;
        base[1] = 32'hA1;
        do_reset();
        vld    = 2'b10;
        r0seen = 0;
        repeat (10) begin
            tick(1);
            if (rdy[0][0]) r0seen = 1;
        end
        check("B i_ready0 low", 32'(r0seen), 32'd0);
        check("B beats", 32'(lg0.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < lg0.size(); i++) begin
            check($sformatf("B data%0d", i), lg0[i].data, 32'hA1 + 32'(i));
            check($sformatf("B sel%0d", i), 32'(lg0[i].sel), 32'd1);
            check($sformatf("B last%0d", i), 32'(lg0[i].last), 32'(i % 2));
        end

        // Granted source 0 stalls mid-burst; source 1 must wait.
        vld     = 2'b00;
        base[0] = 32'h300;
        base[1] = 32'h400;
        do_reset();
        vld = 2'b11;
        wait_seq(0, 0, 32'd1, "C first beat");
        vld = 2'b10;
        tick(5);
        check("C src1 blocked", seq[0][1], 32'd0);
        check("C src0 held", seq[0][0], 32'd1);
        vld = 2'b11;
        tick(10);
        check("C beats", 32'(lg0.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < lg0.size(); i++) begin
            check($sformatf("C sel%0d", i), 32'(lg0[i].sel), 32'(sA0[i]));
            check($sformatf("C last%0d", i), 32'(lg0[i].last), 32'(lA0[i]));
            check($sformatf("C data%0d", i), lg0[i].data,
                  32'(dA0[i]) + 32'h200);
        end

        // Downstream back-pressure holding beat 0x55.
        vld     = 2'b00;
        base[0] = 32'h55;
        do_reset();
        vld = 2'b01;
        t   = 0;
        while (!ov[0] && t < 20) begin
            tick(1);
            t++;
        end
        check("D o_valid rise", 32'(ov[0]), 32'd1);
        ordy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("D hold data", od[0], 32'h55);
            check("D hold sel", 32'(os[0]), 32'd0);
            check("D hold last", 32'(ol[0]), 32'd0);
            check("D i_ready", 32'(rdy[0]), 32'd0);
        end
        tick(1);
        check("D count held", seq[0][0], 32'd1);
        ordy = 1'b1;
        rel  = cyc;
        tick(4);
        check("D beats", 32'(lg0.size() >= 2), 32'd1);
        if (lg0.size() >= 2) begin
            check("D beat0 data", lg0[0].data, 32'h55);
            check("D beat0 cyc", 32'(lg0[0].cyc - rel), 32'd0);
            check("D beat1 data", lg0[1].data, 32'h56);
            check("D beat1 last", 32'(lg0[1].last), 32'd1);
        end

        // Reset in the middle of a source-1 burst.
        vld     = 2'b00;
        base[0] = 32'h100;
        base[1] = 32'hE0;
        do_reset();
        vld = 2'b10;
        wait_seq(0, 1, 32'd1, "E first beat");
        reset = 1'b1;
        vld   = 2'b11;
        tick(1);
        reset = 1'b0;
        lg0.delete();
        lg1.delete();
        @(negedge clk);
        check("E o_valid", 32'(ov[0]), 32'd0);
        check("E i_ready", 32'(rdy[0]), 32'd0);
        tick(6);
        check("E beats", 32'(lg0.size() >= 1), 32'd1);
        if (lg0.size() >= 1) begin
            check("E first sel", 32'(lg0[0].sel), 32'd0);
            check("E first data", lg0[0].data, 32'h100);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
